f_seq_monitor: RTL and testbench
================================

// Module: f_seq_monitor
// PURPOSE
//   Downstream consumer of the p2c1 output f. Samples f once per clock when enabled
//   and detects a programmable serial bit pattern, in overlapping or non-overlapping mode.
//   Counts detections in a saturating counter and emits a one-cycle match pulse.
//   Sits directly after p2c1 in the project1 datapath and shares its clock.
// PARAMETERS
//   PAT_W     4        pattern length in bits (2..16)
//   PATTERN   4'b1011  target pattern; MSB is the oldest sample, LSB the newest
//   CNT_W     8        width of match counter
//   OVERLAP   1        1: overlapping detection; 0: window restarts after each match
//   STUCK_LIM 16       stuck-detect threshold in samples (used only with STUCK_DET_EN)
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   rst        in   1      asynchronous reset, active-high
//   en         in   1      sample enable; f_in is taken on posedge clk when en=1
//   f_in       in   1      serial bit, driven from p2c1 f
//   clr        in   1      synchronous clear of counter, sat and window history
//   match      out  1      one-cycle pulse, registered
//   match_cnt  out  CNT_W  number of detections, saturating
//   sat        out  1      sticky flag: match_cnt reached all-ones
//   stuck      out  1      only with STUCK_DET_EN; otherwise tied 0
// BEHAVIOUR
//   - Reset (async, immediate, mid-operation included):
//     match=0, match_cnt=0, sat=0, stuck=0, shift reg=0, fill=0, state=FILL.
//   - Window: shift reg sh[PAT_W-1:0]. Each accepted sample updates sh <= {sh[PAT_W-2:0], f_in}.
//     fill counts valid bits, saturating at PAT_W.
//   - FSM states: FILL (fill<PAT_W), SCAN (window full).
//     FILL -> SCAN on the sample that makes fill==PAT_W.
//     SCAN -> FILL only on a non-overlapping match, or on clr.
//   - Compare: done on the new window value {sh[PAT_W-2:0],f_in} at each accepted sample,
//     but only when fill+1>=PAT_W. The completing sample itself counts, so the first
//     possible match is on sample PAT_W.
//   - On match at edge N: match=1 during cycle N..N+1 only; match_cnt increments at edge N.
//     Latency is one clock from the completing sample.
//   - OVERLAP=1: stay in SCAN; bits are reused, e.g. 1011011 gives two matches.
//   - OVERLAP=0: sh<=0, fill<=0, go to FILL; the next match needs PAT_W fresh samples.
//   - en=0: no shift, no compare, state frozen, match=0. Gaps in en are transparent.
//   - Saturation: match_cnt holds at 2^CNT_W-1. sat sets on the edge where the count
//     reaches max, stays set until clr or rst, and further matches still pulse match.
//   - clr=1 (any en): match_cnt=0, sat=0, sh=0, fill=0, state=FILL, stuck cleared.
//     clr wins over a same-cycle match: no pulse, no increment, and the sample is discarded.
//   - f_in must be stable around the posedge clk at which it is sampled.
// CONFIGURATION
//   STUCK_DET_EN defined:
//     - adds a run counter of identical consecutive accepted samples, saturating at STUCK_LIM.
//     - stuck=1 registered on the accepted sample that makes the run reach STUCK_LIM.
//     - stuck clears on the first accepted differing sample, or on clr/rst.
//   STUCK_DET_EN undefined: no run-counter logic; stuck is constant 0.
// TESTING
//   1. rst=1 mid-stream (after 3 samples) -> all outputs 0 at once; the next match
//      needs 4 fresh samples.
//   2. OVERLAP=1, en=1, f_in=1,0,1,1,0,1,1 -> match pulses after samples 4 and 7;
//      match_cnt=2.
//   3. OVERLAP=0, f_in=1,0,1,1,0,1,1,0 -> single pulse after sample 4; match_cnt=1.
//   4. CNT_W=2, four non-adjacent 1011 patterns -> match_cnt=3 and sat=1 after the 3rd
//      match; 4th match pulses with count still 3; then clr=1 -> match_cnt=0, sat=0.
//   5. Samples 1,0, then en=0 for 5 cycles with f_in toggling, then 1,1 with en=1 ->
//      one match, match_cnt=1. Also: clr asserted on the completing sample -> no pulse,
//      count 0.
//   6. STUCK_DET_EN, STUCK_LIM=16: 16 zeros -> stuck=1 after the 16th sample; next
//      f_in=1 -> stuck=0. Without the macro, stuck stays 0 throughout.

Source files
------------

// File: rtl/f_seq_monitor.sv
// Serial pattern monitor on the p2c1 f stream: counts (saturating) and pulses on each pattern hit.
// Optional stuck-input detector enabled by defining STUCK_DET_EN.
module f_seq_monitor #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
  parameter int               CNT_W     = 8,
  parameter bit               OVERLAP   = 1'b1,
  parameter int               STUCK_LIM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             f_in,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat,
  output logic             stuck
);

  localparam int             FW       = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);

  if (PAT_W < 2 || PAT_W > 16 || STUCK_LIM < 1) begin : g_param_check
    $error("f_seq_monitor: parameter out of range");
  end

  typedef enum logic {FILL, SCAN} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             sat_q, sat_d;
  logic [PAT_W-1:0] win;
  logic             hit;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    match_d = 1'b0;
    hit     = 1'b0;
    win     = {sh_q[PAT_W-2:0], f_in};
    if (clr) begin
      state_d = FILL;
      sh_d    = '0;
      fill_d  = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (en) begin
      // The sample that completes the window is already eligible for a match.
      hit = ((state_q == SCAN) || (fill_q == FILL_MAX - 1'b1)) && (win == PATTERN);
      if (hit) begin
        match_d = 1'b1;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_d) sat_d = 1'b1;
        end
      end
      if (hit && !OVERLAP) begin
        state_d = FILL;
        sh_d    = '0;
        fill_d  = '0;
      end else begin
        sh_d = win;
        if (state_q == FILL) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_MAX - 1'b1) state_d = SCAN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      sh_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      sat_q   <= sat_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;

`ifdef STUCK_DET_EN
  localparam int            RW       = $clog2(STUCK_LIM + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(STUCK_LIM);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic          stuck_q, stuck_d;

  // run_q==0 means no accepted sample since reset/clear, so last_q is meaningless.
  always_comb begin
    run_d   = run_q;
    last_d  = last_q;
    stuck_d = stuck_q;
    if (clr) begin
      run_d   = '0;
      stuck_d = 1'b0;
    end else if (en) begin
      last_d = f_in;
      if (run_q == '0 || f_in != last_q) run_d = RUN_ONE;
      else if (run_q != RUN_MAX)         run_d = run_q + 1'b1;
      stuck_d = (run_d == RUN_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= '0;
      last_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      last_q  <= last_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_f_seq_monitor.sv
// Bench for f_seq_monitor: two instances (overlapping 8-bit count, non-overlapping 2-bit count)
// checked every cycle against a queue-based reference model, plus directed literal checks.
module tb_f_seq_monitor;

  logic       clk = 1'b0;
  logic       rst, en, f_in, clr;
  logic       match0, sat0, stuck0;
  logic [7:0] cnt0;
  logic       match1, sat1, stuck1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  f_seq_monitor #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b1), .STUCK_LIM(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .f_in(f_in), .clr(clr),
    .match(match0), .match_cnt(cnt0), .sat(sat0), .stuck(stuck0)
  );

  f_seq_monitor #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b0), .STUCK_LIM(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .f_in(f_in), .clr(clr),
    .match(match1), .match_cnt(cnt1), .sat(sat1), .stuck(stuck1)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

`ifdef STUCK_DET_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  // Reference model: accepted-sample histories as queues.
  logic [3:0] pat_bits = 4'b1011;
  int         cnt_max[2] = '{255, 3};
  bit         overlap[2] = '{1'b1, 1'b0};
  int         exp_match[2];
  int         exp_cnt[2];
  int         exp_stuck;
  bit         win0[$];
  bit         win1[$];
  bit         hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tail_match(input bit q[$]);
    int n = q.size();
    if (n < 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (q[n - 4 + i] != pat_bits[3 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int trailing_run(input bit q[$]);
    int r = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] == q[q.size() - 1]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_match[k] = 0;
      exp_cnt[k]   = 0;
    end
    exp_stuck = 0;
    win0.delete();
    win1.delete();
    hist.delete();
  endtask

  task automatic model_step(input bit e, input bit f, input bit c);
    bit hit;
    exp_match[0] = 0;
    exp_match[1] = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      hist.push_back(f);
      if (hist.size() > 40) void'(hist.pop_front());
      win0.push_back(f);
      win1.push_back(f);
      if (win0.size() > 8) void'(win0.pop_front());
      if (win1.size() > 8) void'(win1.pop_front());
      for (int k = 0; k < 2; k++) begin
        hit = (k == 0) ? tail_match(win0) : tail_match(win1);
        if (hit) begin
          exp_match[k] = 1;
          if (exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
          if (!overlap[k]) begin
            if (k == 0) win0.delete();
            else        win1.delete();
          end
        end
      end
      exp_stuck = (STUCK_ON && trailing_run(hist) >= 16) ? 1 : 0;
    end
  endtask

  task automatic cmp_all();
    chk("match0", 32'(match0), 32'(exp_match[0]));
    chk("cnt0",   32'(cnt0),   32'(exp_cnt[0]));
    chk("sat0",   32'(sat0),   32'(exp_cnt[0] == cnt_max[0]));
    chk("stuck0", 32'(stuck0), 32'(exp_stuck));
    chk("match1", 32'(match1), 32'(exp_match[1]));
    chk("cnt1",   32'(cnt1),   32'(exp_cnt[1]));
    chk("sat1",   32'(sat1),   32'(exp_cnt[1] == cnt_max[1]));
    chk("stuck1", 32'(stuck1), 32'(exp_stuck));
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic run_cycle(input bit e, input bit f, input bit c);
    en = e; f_in = f; clr = c;
    @(posedge clk);
    model_step(e, f, c);
    @(negedge clk);
    txn++;
    $display("txn %0d en=%0b f=%0b clr=%0b | m0=%0b c0=%0d s0=%0b | m1=%0b c1=%0d s1=%0b | stuck=%0b",
             txn, e, f, c, match0, cnt0, sat0, match1, cnt1, sat1, stuck0);
    cmp_all();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) run_cycle(1'b1, bits[i], 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_match0", 32'(match0), 32'd0);
    chk("rst_cnt0",   32'(cnt0),   32'd0);
    chk("rst_sat1",   32'(sat1),   32'd0);
    chk("rst_stuck0", 32'(stuck0), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; f_in = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_match", 32'(match0), 32'd0);
    chk("reset_cnt",   32'(cnt0),   32'd0);
    chk("reset_sat",   32'(sat0),   32'd0);
    chk("reset_stuck", 32'(stuck1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    cmp_all();

    // Overlapping 1011011: hits on samples 4 and 7; non-overlap sees only one.
    run_cycle(1'b0, 1'b0, 1'b1);
    send_bits(16'b1011, 4);
    chk("ovl_first_pulse", 32'(match0), 32'd1);
    send_bits(16'b011, 3);
    chk("ovl_second_pulse", 32'(match0), 32'd1);
    chk("ovl_cnt", 32'(cnt0), 32'd2);
    run_cycle(1'b1, 1'b0, 1'b0);
    chk("novl_cnt", 32'(cnt1), 32'd1);
    chk("novl_no_pulse", 32'(match1), 32'd0);

    // Saturation on the 2-bit counter, then clear.
    run_cycle(1'b0, 1'b0, 1'b1);
    for (int p = 1; p <= 4; p++) begin
      send_bits(16'b1011, 4);
      if (p == 3) begin
        chk("sat_cnt3", 32'(cnt1), 32'd3);
        chk("sat_flag", 32'(sat1), 32'd1);
      end
      if (p == 4) begin
        chk("sat_pulse4", 32'(match1), 32'd1);
        chk("sat_hold", 32'(cnt1), 32'd3);
      end
      run_cycle(1'b1, 1'b0, 1'b0);
    end
    run_cycle(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", 32'(cnt1), 32'd0);
    chk("clr_sat", 32'(sat1), 32'd0);

    // Enable gaps are transparent.
    send_bits(16'b10, 2);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'(i & 1), 1'b0);
    send_bits(16'b11, 2);
    chk("gap_pulse", 32'(match0), 32'd1);
    chk("gap_cnt", 32'(cnt0), 32'd1);

    // Clear on the completing sample wins.
    run_cycle(1'b0, 1'b0, 1'b1);
    send_bits(16'b101, 3);
    run_cycle(1'b1, 1'b1, 1'b1);
    chk("clrwin_pulse", 32'(match0), 32'd0);
    chk("clrwin_cnt", 32'(cnt0), 32'd0);

    // Async reset after 3 samples; the window must refill from scratch.
    send_bits(16'b101, 3);
    mid_reset();
    run_cycle(1'b1, 1'b1, 1'b0);
    chk("rst_no_stale", 32'(match0), 32'd0);
    send_bits(16'b011, 3);
    chk("rst_fresh_pulse", 32'(match0), 32'd1);
    chk("rst_fresh_cnt", 32'(cnt0), 32'd1);

    // Stuck detection on a run of 16 zeros.
    run_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) run_cycle(1'b1, 1'b0, 1'b0);
    chk("stuck_15", 32'(stuck0), 32'd0);
    run_cycle(1'b1, 1'b0, 1'b0);
    chk("stuck_16", 32'(stuck0), 32'(STUCK_ON));
    run_cycle(1'b1, 1'b1, 1'b0);
    chk("stuck_release", 32'(stuck0), 32'd0);

    // Randomized stream against the model.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) mid_reset();
      run_cycle($urandom_range(0, 3) != 0,
                (i % 100 < 20) ? 1'b1 : 1'($urandom_range(0, 1)),
                $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
